// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel registered stream mux. It arbitrates by round-robin or by fixed
// select, and it holds one output beat that can be drained and refilled in the same cycle.
module rr_stream_mux #(
  parameter  int N    = 8,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_sel_q, out_sel_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic            load;
  logic            grant_found;
  logic [SELW-1:0] grant_idx;
  logic [W-1:0]    grant_data;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    if (mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
    end else begin
      // Scan the wrapped region first, so any requester at or above ptr_q overrides it.
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i] && SELW'(i) < ptr_q) begin
          grant_found = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i] && SELW'(i) >= ptr_q) begin
          grant_found = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data = in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    load        = !rst && (!out_valid_q || out_ready);
    in_ready    = '0;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load && grant_found && (grant_idx == SELW'(i));
    end
    if (load) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        out_data_d = grant_data;
        out_sel_d  = grant_idx;
        // An explicit wrap keeps ptr in range when N is not a power of two.
        if (!mode) begin
          ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux. It drives an N=8 and an N=5 instance and checks
// them against a queue-free behavioural model of the output register and the arbitration rules.
module tb_rr_stream_mux;

  logic        clk;
  logic        rst;

  logic [63:0] in_data8;
  logic [7:0]  in_valid8;
  logic [7:0]  in_ready8;
  logic        mode8;
  logic [2:0]  sel8;
  logic [7:0]  out_data8;
  logic [2:0]  out_sel8;
  logic        out_valid8;
  logic        out_ready8;

  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic        mode5;
  logic [2:0]  sel5;
  logic [7:0]  out_data5;
  logic [2:0]  out_sel5;
  logic        out_valid5;
  logic        out_ready5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         valid;
    logic [7:0] data;
    int         sel;
    int         ptr;
  } model_t;

  model_t st8, nxt8, st5, nxt5;
  logic [7:0] exp_rdy8, exp_rdy5;

  rr_stream_mux #(.N(8), .W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .mode(mode8), .sel(sel8), .out_data(out_data8), .out_sel(out_sel8),
    .out_valid(out_valid8), .out_ready(out_ready8)
  );

  rr_stream_mux #(.N(5), .W(8)) dut5 (
    .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .mode(mode5), .sel(sel5), .out_data(out_data5), .out_sel(out_sel5),
    .out_valid(out_valid5), .out_ready(out_ready5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbitration stated directly: the first valid channel at ptr, ptr+1, ... modulo n,
  // or the selected channel when it is in range and valid.
  function automatic void model_next(input int n, input model_t cur, input logic m, input int s,
                                     input logic [7:0] v, input logic [63:0] d, input logic ordy,
                                     output logic [7:0] rdy, output model_t nxt);
    bit found;
    int g;
    nxt   = cur;
    rdy   = '0;
    found = 0;
    g     = 0;
    if (m) begin
      if (s < n && v[s]) begin
        found = 1;
        g     = s;
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        int idx;
        idx = (cur.ptr + k) % n;
        if (!found && v[idx]) begin
          found = 1;
          g     = idx;
        end
      end
    end
    if (!cur.valid || ordy) begin
      if (found) begin
        rdy[g]    = 1'b1;
        nxt.valid = 1;
        nxt.data  = d[g*8 +: 8];
        nxt.sel   = g;
        if (!m) nxt.ptr = (g + 1) % n;
      end else begin
        nxt.valid = 0;
      end
    end
  endfunction

  task automatic predict();
    model_next(8, st8, mode8, int'(sel8), in_valid8, in_data8, out_ready8, exp_rdy8, nxt8);
    model_next(5, st5, mode5, int'(sel5), {3'b000, in_valid5}, {24'h0, in_data5}, out_ready5,
               exp_rdy5, nxt5);
    if (rst) begin
      exp_rdy8 = '0;
      exp_rdy5 = '0;
    end
  endtask

  task automatic model_reset();
    st8 = '{1'b0, 8'h00, 0, 0};
    st5 = '{1'b0, 8'h00, 0, 0};
  endtask

  task automatic step();
    predict();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      st8 = nxt8;
      st5 = nxt5;
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    mode8      = 1'b0;
    sel8       = '0;
    in_valid8  = 8'hFF;
    out_ready8 = 1'b1;
    for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = 8'h10 + 8'(i);
    mode5      = 1'b0;
    sel5       = '0;
    in_valid5  = '0;
    out_ready5 = 1'b1;
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'h30 + 8'(i);
    model_reset();
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      predict();
      checks++;
      if (in_ready8 !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_in_ready: got %b expected 00000000", in_ready8);
      end
      step();
      checks++;
      if (out_valid8 !== 1'b0 || out_data8 !== 8'h00 || out_sel8 !== 3'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got valid=%b data=%h sel=%0d expected 0/00/0",
                 out_valid8, out_data8, out_sel8);
      end
    end
    rst = 1'b0;
    #1;
    predict();
    checks++;
    if (in_ready8 !== 8'h01) begin
      errors++;
      $display("[TB] FAIL reset_first_grant_ready: got %b expected 00000001", in_ready8);
    end
    step();
    checks++;
    if (out_valid8 !== 1'b1 || out_sel8 !== 3'd0 || out_data8 !== 8'h10) begin
      errors++;
      $display("[TB] FAIL reset_first_grant: got valid=%b sel=%0d data=%h expected 1/0/10",
               out_valid8, out_sel8, out_data8);
    end
  endtask

  task automatic test_rr_sweep();
    reset_pulse();
    mode8      = 1'b0;
    in_valid8  = 8'hFF;
    out_ready8 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      predict();
      checks++;
      if (in_ready8 !== 8'(1 << (c % 8))) begin
        errors++;
        $display("[TB] FAIL sweep_in_ready[%0d]: got %b expected %b", c, in_ready8, 8'(1 << (c % 8)));
      end
      step();
      checks++;
      if (out_valid8 !== 1'b1 || out_sel8 !== 3'(c % 8) || out_data8 !== 8'h10 + 8'(c % 8)) begin
        errors++;
        $display("[TB] FAIL sweep_beat[%0d]: got valid=%b sel=%0d data=%h expected 1/%0d/%h",
                 c, out_valid8, out_sel8, out_data8, c % 8, 8'h10 + 8'(c % 8));
      end
    end
  endtask

  task automatic test_sparse_wrap();
    int exp_seq[3] = '{7, 2, 7};
    reset_pulse();
    mode8      = 1'b0;
    out_ready8 = 1'b1;
    in_valid8  = 8'h04;
    #1;
    predict();
    step();
    checks++;
    if (out_sel8 !== 3'd2) begin
      errors++;
      $display("[TB] FAIL sparse_setup: got sel=%0d expected 2", out_sel8);
    end
    in_valid8 = 8'h84;
    for (int c = 0; c < 3; c++) begin
      #1;
      predict();
      checks++;
      if (in_ready8 !== 8'(1 << exp_seq[c])) begin
        errors++;
        $display("[TB] FAIL sparse_in_ready[%0d]: got %b expected %b", c, in_ready8,
                 8'(1 << exp_seq[c]));
      end
      step();
      checks++;
      if (out_sel8 !== 3'(exp_seq[c]) || out_data8 !== 8'h10 + 8'(exp_seq[c])) begin
        errors++;
        $display("[TB] FAIL sparse_beat[%0d]: got sel=%0d data=%h expected %0d/%h",
                 c, out_sel8, out_data8, exp_seq[c], 8'h10 + 8'(exp_seq[c]));
      end
    end
  endtask

  task automatic test_backpressure();
    in_valid8  = 8'hFF;
    out_ready8 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      predict();
      checks++;
      if (in_ready8 !== 8'h00) begin
        errors++;
        $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 00000000", c, in_ready8);
      end
      step();
      checks++;
      if (out_valid8 !== 1'b1 || out_sel8 !== 3'd7 || out_data8 !== 8'h17) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b sel=%0d data=%h expected 1/7/17",
                 c, out_valid8, out_sel8, out_data8);
      end
    end
    out_ready8 = 1'b1;
    #1;
    predict();
    checks++;
    if (in_ready8 !== 8'h01) begin
      errors++;
      $display("[TB] FAIL bp_release_ready: got %b expected 00000001", in_ready8);
    end
    step();
    checks++;
    if (out_valid8 !== 1'b1 || out_sel8 !== 3'd0 || out_data8 !== 8'h10) begin
      errors++;
      $display("[TB] FAIL bp_release_beat: got valid=%b sel=%0d data=%h expected 1/0/10",
               out_valid8, out_sel8, out_data8);
    end
  endtask

  task automatic test_fixed_select();
    mode8      = 1'b1;
    sel8       = 3'd5;
    in_valid8  = 8'hFF;
    out_ready8 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      predict();
      checks++;
      if (in_ready8 !== 8'h20) begin
        errors++;
        $display("[TB] FAIL fixed_in_ready[%0d]: got %b expected 00100000", c, in_ready8);
      end
      step();
      checks++;
      if (out_valid8 !== 1'b1 || out_sel8 !== 3'd5 || out_data8 !== 8'h15) begin
        errors++;
        $display("[TB] FAIL fixed_beat[%0d]: got valid=%b sel=%0d data=%h expected 1/5/15",
                 c, out_valid8, out_sel8, out_data8);
      end
    end
    in_valid8 = 8'hDF;
    #1;
    predict();
    checks++;
    if (in_ready8 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL fixed_idle_ready: got %b expected 00000000", in_ready8);
    end
    step();
    checks++;
    if (out_valid8 !== 1'b0 || out_sel8 !== 3'd5) begin
      errors++;
      $display("[TB] FAIL fixed_drain: got valid=%b sel=%0d expected 0/5", out_valid8, out_sel8);
    end
    // The pointer was left at 1 by the last round-robin grant and must survive fixed mode.
    mode8     = 1'b0;
    in_valid8 = 8'hFF;
    #1;
    predict();
    step();
    checks++;
    if (out_valid8 !== 1'b1 || out_sel8 !== 3'd1) begin
      errors++;
      $display("[TB] FAIL fixed_ptr_kept: got valid=%b sel=%0d expected 1/1", out_valid8, out_sel8);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = 8'hA0 + 8'(i);
    mode8      = 1'b0;
    in_valid8  = 8'hFF;
    out_ready8 = 1'b1;
    #1;
    predict();
    step();
    checks++;
    if (out_valid8 !== 1'b1 || out_sel8 !== 3'd2 || out_data8 !== 8'hA2) begin
      errors++;
      $display("[TB] FAIL midrst_fill: got valid=%b sel=%0d data=%h expected 1/2/A2",
               out_valid8, out_sel8, out_data8);
    end
    out_ready8 = 1'b0;
    rst        = 1'b1;
    #1;
    model_reset();
    checks++;
    if (out_valid8 !== 1'b0 || out_data8 !== 8'h00 || out_sel8 !== 3'd0 || in_ready8 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midrst_async: got valid=%b data=%h sel=%0d ready=%b expected 0/00/0/0",
               out_valid8, out_data8, out_sel8, in_ready8);
    end
    step();
    rst        = 1'b0;
    out_ready8 = 1'b1;
    #1;
    predict();
    step();
    checks++;
    if (out_valid8 !== 1'b1 || out_sel8 !== 3'd0 || out_data8 !== 8'hA0) begin
      errors++;
      $display("[TB] FAIL midrst_restart: got valid=%b sel=%0d data=%h expected 1/0/A0",
               out_valid8, out_sel8, out_data8);
    end
  endtask

  task automatic test_random8();
    for (int c = 0; c < 400; c++) begin
      mode8      = ($urandom_range(0, 3) == 0);
      sel8       = 3'($urandom_range(0, 7));
      in_valid8  = 8'($urandom);
      out_ready8 = ($urandom_range(0, 9) < 7);
      in_data8   = {$urandom, $urandom};
      #1;
      predict();
      checks++;
      if (in_ready8 !== exp_rdy8) begin
        errors++;
        $display("[TB] FAIL rand8_in_ready[%0d]: got %b expected %b", c, in_ready8, exp_rdy8);
      end
      step();
      checks++;
      if (out_valid8 !== st8.valid || out_data8 !== st8.data || out_sel8 !== 3'(st8.sel)) begin
        errors++;
        $display("[TB] FAIL rand8_out[%0d]: got valid=%b data=%h sel=%0d expected %b/%h/%0d",
                 c, out_valid8, out_data8, out_sel8, st8.valid, st8.data, st8.sel);
      end
    end
  endtask

  task automatic test_n5();
    in_valid8  = '0;
    reset_pulse();
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'h30 + 8'(i);
    mode5      = 1'b1;
    sel5       = 3'd6;
    in_valid5  = 5'h1F;
    out_ready5 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      predict();
      checks++;
      if (in_ready5 !== 5'h00) begin
        errors++;
        $display("[TB] FAIL n5_oob_ready[%0d]: got %b expected 00000", c, in_ready5);
      end
      step();
      checks++;
      if (out_valid5 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL n5_oob_valid[%0d]: got %b expected 0", c, out_valid5);
      end
    end
    mode5 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      predict();
      checks++;
      if (in_ready5 !== 5'(1 << (c % 5))) begin
        errors++;
        $display("[TB] FAIL n5_rr_ready[%0d]: got %b expected %b", c, in_ready5, 5'(1 << (c % 5)));
      end
      step();
      checks++;
      if (out_valid5 !== 1'b1 || out_sel5 !== 3'(c % 5) || out_data5 !== 8'h30 + 8'(c % 5)) begin
        errors++;
        $display("[TB] FAIL n5_rr_beat[%0d]: got valid=%b sel=%0d data=%h expected 1/%0d/%h",
                 c, out_valid5, out_sel5, out_data5, c % 5, 8'h30 + 8'(c % 5));
      end
    end
    for (int c = 0; c < 250; c++) begin
      mode5      = ($urandom_range(0, 3) == 0);
      sel5       = 3'($urandom_range(0, 7));
      in_valid5  = 5'($urandom);
      out_ready5 = ($urandom_range(0, 9) < 7);
      in_data5   = {8'($urandom), $urandom};
      #1;
      predict();
      checks++;
      if (in_ready5 !== exp_rdy5[4:0]) begin
        errors++;
        $display("[TB] FAIL rand5_in_ready[%0d]: got %b expected %b", c, in_ready5, exp_rdy5[4:0]);
      end
      step();
      checks++;
      if (out_valid5 !== st5.valid || out_data5 !== st5.data || out_sel5 !== 3'(st5.sel)) begin
        errors++;
        $display("[TB] FAIL rand5_out[%0d]: got valid=%b data=%h sel=%0d expected %b/%h/%0d",
                 c, out_valid5, out_data5, out_sel5, st5.valid, st5.data, st5.sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_sweep();
    test_sparse_wrap();
    test_backpressure();
    test_fixed_select();
    test_mid_reset();
    test_random8();
    test_n5();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
